// File: rtl/sdp_ram_pkg.sv
// Shared definitions for the byte-enable simple dual-port RAM:
// zero-fill FSM state encoding and read-latency helper.
package sdp_ram_pkg;

  localparam int BYTE_BITS = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_READY = 2'd2
  } fill_state_e;

  function automatic int readLatency(input bit outReg);
    return outReg ? 2 : 1;
  endfunction

endpackage

// File: rtl/sdp_ram_core.sv
// Plain byte-enable memory array with a registered read port; the array itself
// carries no reset so it maps onto block RAM.
module sdp_ram_core import sdp_ram_pkg::*; #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                             clk,
  input  logic                             i_rst,
  input  logic                             i_wrEn,
  input  logic [ADDR_WIDTH-1:0]            i_wrAddr,
  input  logic [DATA_WIDTH/BYTE_BITS-1:0]  i_wrBe,
  input  logic [DATA_WIDTH-1:0]            i_wrData,
  input  logic                             i_rdEn,
  input  logic [ADDR_WIDTH-1:0]            i_rdAddr,
  output logic [DATA_WIDTH-1:0]            o_rdData
);

  localparam int BE_WIDTH = DATA_WIDTH / BYTE_BITS;
  localparam int DEPTH    = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DATA_WIDTH-1:0] r_rdData;

  always_ff @(posedge clk) begin
    if (i_wrEn) begin
      for (int i = 0; i < BE_WIDTH; i++) begin
        if (i_wrBe[i]) begin
          r_mem[i_wrAddr][i*BYTE_BITS +: BYTE_BITS] <= i_wrData[i*BYTE_BITS +: BYTE_BITS];
        end
      end
    end
  end

  // Read samples the array before this edge's write lands, so a colliding read sees old data.
  always_ff @(posedge clk) begin
    if (i_rst) begin
      r_rdData <= '0;
    end else if (i_rdEn) begin
      r_rdData <= r_mem[i_rdAddr];
    end
  end

  assign o_rdData = r_rdData;

endmodule

// File: rtl/sdp_ram_be.sv
// Byte-enable simple dual-port RAM wrapper: zero-fill FSM, read-during-write
// bypass merge and optional output register around sdp_ram_core.
module sdp_ram_be import sdp_ram_pkg::*; #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 10,
  parameter int OUT_REG      = 0,
  parameter int RDW_NEW      = 0,
  parameter int CLEAR_ON_RST = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_en,
  input  logic [ADDR_WIDTH-1:0]   wr_addr,
  input  logic [DATA_WIDTH/8-1:0] wr_be,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  input  logic                    rd_en,
  input  logic [ADDR_WIDTH-1:0]   rd_addr,
  output logic [DATA_WIDTH-1:0]   rd_data,
  output logic                    rd_valid,
  output logic                    init_busy
);

  localparam int BE_WIDTH    = DATA_WIDTH / BYTE_BITS;
  localparam int ReadLatency = readLatency(OUT_REG != 0);

  fill_state_e             r_state;
  fill_state_e             w_nextState;
  logic [ADDR_WIDTH-1:0]   r_clearAddr;
  logic                    w_busy;
  logic                    w_clearing;

  logic                    w_userWr;
  logic                    w_clearWr;
  logic                    w_rdAccept;
  logic                    w_memWrEn;
  logic [ADDR_WIDTH-1:0]   w_memWrAddr;
  logic [BE_WIDTH-1:0]     w_memWrBe;
  logic [DATA_WIDTH-1:0]   w_memWrData;
  logic [DATA_WIDTH-1:0]   w_coreData;
  logic [DATA_WIDTH-1:0]   w_mergedData;

  logic                    r_rdValid1;
  logic [BE_WIDTH-1:0]     r_bypassBe;
  logic [DATA_WIDTH-1:0]   r_bypassData;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_clearAddr <= '0;
    end else begin
      r_state <= w_nextState;
      if (w_clearing && (r_clearAddr != '1)) begin
        r_clearAddr <= r_clearAddr + 1'b1;
      end
    end
  end

  always_comb begin
    w_nextState = r_state;
    w_busy      = 1'b0;
    w_clearing  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_busy      = 1'b1;
        w_nextState = (CLEAR_ON_RST != 0) ? ST_CLEAR : ST_READY;
      end
      ST_CLEAR: begin
        w_busy     = 1'b1;
        w_clearing = 1'b1;
        if (r_clearAddr == '1) begin
          w_nextState = ST_READY;
        end
      end
      ST_READY: begin
        w_nextState = ST_READY;
      end
      default: begin
        w_nextState = ST_IDLE;
      end
    endcase
  end

  assign init_busy  = w_busy;
  assign w_userWr   = wr_en && (wr_be != '0) && (r_state == ST_READY) && !rst;
  assign w_clearWr  = w_clearing && !rst;
  assign w_rdAccept = rd_en && (r_state == ST_READY);

  // Fill traffic owns the write port while busy; user writes are only seen in READY.
  assign w_memWrEn   = w_clearWr || w_userWr;
  assign w_memWrAddr = w_clearing ? r_clearAddr : wr_addr;
  assign w_memWrBe   = w_clearing ? {BE_WIDTH{1'b1}} : wr_be;
  assign w_memWrData = w_clearing ? '0 : wr_data;

  sdp_ram_core #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_core (
    .clk      (clk),
    .i_rst    (rst),
    .i_wrEn   (w_memWrEn),
    .i_wrAddr (w_memWrAddr),
    .i_wrBe   (w_memWrBe),
    .i_wrData (w_memWrData),
    .i_rdEn   (w_rdAccept),
    .i_rdAddr (rd_addr),
    .o_rdData (w_coreData)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rdValid1   <= 1'b0;
      r_bypassBe   <= '0;
      r_bypassData <= '0;
    end else begin
      r_rdValid1 <= w_rdAccept;
      if (w_rdAccept) begin
        r_bypassBe   <= ((RDW_NEW != 0) && w_userWr && (wr_addr == rd_addr)) ? wr_be : '0;
        r_bypassData <= wr_data;
      end
    end
  end

  // Overlay the colliding write's enabled bytes on the old word read by the core.
  always_comb begin
    w_mergedData = w_coreData;
    for (int i = 0; i < BE_WIDTH; i++) begin
      if (r_bypassBe[i]) begin
        w_mergedData[i*BYTE_BITS +: BYTE_BITS] = r_bypassData[i*BYTE_BITS +: BYTE_BITS];
      end
    end
  end

  if (ReadLatency == 2) begin : g_outReg
    logic [DATA_WIDTH-1:0] r_outData;
    logic                  r_outValid;

    always_ff @(posedge clk) begin
      if (rst) begin
        r_outData  <= '0;
        r_outValid <= 1'b0;
      end else begin
        r_outValid <= r_rdValid1;
        if (r_rdValid1) begin
          r_outData <= w_mergedData;
        end
      end
    end

    assign rd_data  = r_outData;
    assign rd_valid = r_outValid;
  end else begin : g_noOutReg
    assign rd_data  = w_mergedData;
    assign rd_valid = r_rdValid1;
  end

endmodule

// File: doc/sdp_ram_be.md
SDP_RAM_BE -- requirements
Module: sdp_ram_be

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, word width in bits; must be a multiple of 8.
REQ-002 SHALL have parameter ADDR_WIDTH, default 10, address width; DEPTH = 2**ADDR_WIDTH words.
REQ-003 SHALL have parameter OUT_REG, default 0; 1 adds an output register, giving read latency 2.
REQ-004 SHALL have parameter RDW_NEW, default 0; 0 means a same-address read-during-write returns old data, 1 means it returns new (merged) data.
REQ-005 SHALL have parameter CLEAR_ON_RST, default 1; 1 enables zero-fill of the whole array after reset.
REQ-006 SHALL have port clk, input, 1, single clock for all logic.
REQ-007 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-008 SHALL have port wr_en, input, 1, write request.
REQ-009 SHALL have port wr_addr, input, ADDR_WIDTH, write address.
REQ-010 SHALL have port wr_be, input, DATA_WIDTH/8, byte enables; bit i covers bits [8i+7:8i].
REQ-011 SHALL have port wr_data, input, DATA_WIDTH, write data.
REQ-012 SHALL have port rd_en, input, 1, read request.
REQ-013 SHALL have port rd_addr, input, ADDR_WIDTH, read address.
REQ-014 SHALL have port rd_data, output, DATA_WIDTH, read data, held between reads.
REQ-015 SHALL have port rd_valid, output, 1, one-cycle pulse qualifying rd_data.
REQ-016 SHALL have port init_busy, output, 1, high while the zero-fill is in progress.

Function
REQ-017 SHALL, on a write accepted at edge N, update only the enabled bytes at wr_addr; disabled bytes are retained.
REQ-018 SHALL treat wr_en=1 with wr_be=0 as a no-op.
REQ-019 SHALL, for OUT_REG=0, present mem[rd_addr] on rd_data with rd_valid=1 after the edge following a read accepted at edge N, i.e. valid in cycle N+1.
REQ-020 SHALL, for OUT_REG=1, delay rd_data and rd_valid by one further cycle, i.e. valid in cycle N+2; back-to-back reads sustain one result per cycle.
REQ-021 SHALL hold rd_data at its last value when rd_valid=0.
REQ-022 SHALL, for a same-cycle read and write to the same address, return the pre-write word when RDW_NEW=0, or the byte-merged post-write word when RDW_NEW=1.
REQ-023 SHALL treat read and write to different addresses in the same cycle as independent.
REQ-024 SHALL implement a zero-fill FSM with states IDLE, CLEAR and READY.
REQ-025 SHALL, for the zero-fill FSM, perform these transitions: reset to CLEAR if CLEAR_ON_RST=1, else READY; CLEAR writes zero to counter address 0..DEPTH-1 at one word per cycle; CLEAR goes to READY after address DEPTH-1; IDLE is used only for one cycle during reset.
REQ-026 SHALL drive init_busy=1 in IDLE and CLEAR, for exactly DEPTH+1 cycles after rst falls.
REQ-027 SHALL ignore wr_en and rd_en while init_busy=1: no array update and no rd_valid.
REQ-028 SHALL make the clear counter exactly ADDR_WIDTH bits, with terminal detection at all-ones and no wrap into a second pass.

Reset
REQ-029 SHALL, while rst=1 at an edge, clear rd_data to 0, rd_valid to 0, the pipeline stages to 0 and the clear counter to 0, and set the FSM to IDLE.
REQ-030 SHALL, on rst asserted mid-CLEAR, abort the fill and restart it from address 0 after release.
REQ-031 SHALL not reset array contents via rst except through the zero-fill.

Structure
REQ-032 SHALL place the FSM state encoding (IDLE/CLEAR/READY) and the latency helper function in a shared package sdp_ram_pkg.
REQ-033 SHALL use one sub-module sdp_ram_core: a plain byte-enable array with registered read and no reset on the array, so it infers block RAM; the FSM, bypass and output register sit in sdp_ram_be.

Verification
REQ-034 SHALL cover: DATA_WIDTH=32, ADDR_WIDTH=4, CLEAR_ON_RST=1; release rst -> init_busy high 17 cycles; then reads of addresses 0..15 each return 0x00000000.
REQ-035 SHALL cover: write 0xAABBCCDD to addr 3 with be=1111, then write 0x11223344 with be=0101, then read addr 3 -> 0xAA22CC44, rd_valid in cycle N+1 for OUT_REG=0 and N+2 for OUT_REG=1.
REQ-036 SHALL cover: addr 5 holds 0x0; same-cycle write 0xFFFFFFFF (be=1111) and read of addr 5 -> 0x00000000 when RDW_NEW=0, 0xFFFFFFFF when RDW_NEW=1.
REQ-037 SHALL cover: rd_en and wr_en pulsed during CLEAR -> no rd_valid, and the written address reads 0 after READY.
REQ-038 SHALL cover: rst asserted at clear address 7 for 1 cycle -> init_busy stays high, fill restarts at 0, and busy lasts 17 cycles after release.
REQ-039 SHALL cover: 16 back-to-back reads with OUT_REG=1 -> 16 consecutive rd_valid pulses and correct data order.
